// File: rtl/fb_write_arbiter.sv
// Write-port controller for the 176x144 RGB444 frame buffer. It shares the single
// write port between the camera capture, the clear engine and the CPU write port.
module fb_write_arbiter #(
    parameter int DW     = 12,
    parameter int AW     = 15,
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          cap_start,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    input  logic          cam_frame_start,
    input  logic          cam_valid,
    input  logic [DW-1:0] cam_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic          cpu_ack,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int            FRAME     = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] color_q, color_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          cam_wr;
    logic          clr_wr;
    logic          cpu_slot;
    logic          cpu_take;
    logic          cpu_in_frame;

    // Port ownership for this cycle. busy_q trails state_q by one cycle, so the
    // first CLEAR cycle (busy_q still 0) is a priming cycle without a write.
    always_comb begin
        cam_wr   = 1'b0;
        clr_wr   = 1'b0;
        cpu_slot = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpu_slot = 1'b1;
            end
            S_ARM: begin
                cam_wr   = cam_frame_start && cam_valid;
                cpu_slot = !cam_wr;
            end
            S_CAPTURE: begin
                cam_wr   = cam_valid && !cam_frame_start;
                cpu_slot = !cam_valid;
            end
            S_CLEAR: begin
                clr_wr = busy_q;
            end
            default: begin
                cpu_slot = 1'b0;
            end
        endcase
    end

    assign cpu_take     = cpu_req && !cpu_ack_q && cpu_slot;
    assign cpu_in_frame = (cpu_addr <= LAST_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    color_d = clr_color;
                    err_d   = 1'b0;
                end else if (cap_start) begin
                    state_d = S_ARM;
                    err_d   = 1'b0;
                end
            end
            S_ARM: begin
                if (cam_frame_start) begin
                    state_d = S_CAPTURE;
                    cnt_d   = cam_valid ? AW'(1) : '0;
                end
            end
            S_CAPTURE: begin
                if (cam_frame_start) begin
                    // A new frame began before this one filled the buffer.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cam_valid) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (clr_wr) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write mux with clear > camera > CPU priority; out-of-frame CPU writes are
    // acknowledged but leave the port idle.
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        if (clr_wr) begin
            ram_we_d   = 1'b1;
            ram_addr_d = cnt_q;
            ram_data_d = color_q;
        end else if (cam_wr) begin
            ram_we_d   = 1'b1;
            ram_addr_d = (state_q == S_ARM) ? '0 : cnt_q;
            ram_data_d = cam_data;
        end else if (cpu_take && cpu_in_frame) begin
            ram_we_d   = 1'b1;
            ram_addr_d = cpu_addr;
            ram_data_d = cpu_data;
        end
    end

    // done fires on the first idle cycle after an operation, which is also
    // when busy (one cycle behind state) drops.
    always_comb begin
        cpu_ack_d = cpu_take;
        busy_d    = (state_q != S_IDLE);
        done_d    = (state_q == S_IDLE) && busy_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            color_q    <= '0;
            cpu_ack_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            cpu_ack_q  <= cpu_ack_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cpu_ack  = cpu_ack_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
